// File: rtl/galvo_scan_gen.sv
// rtl/galvo_scan_gen.sv - triangular galvo setpoint generator with end dwell (optional frame counter: GALVO_FRAME_CNT_EN)
module galvo_scan_gen #(
    parameter int          SAMPLE_DIV = 200,
    parameter logic [15:0] PARK_CODE  = 16'd32768
) (
    input  logic        clk_ref,
    input  logic        sys_rstn,
    input  logic        run,
    input  logic [15:0] lim_lo,
    input  logic [15:0] lim_hi,
    input  logic [15:0] step,
    input  logic [7:0]  dwell,
    output logic [15:0] dac_data,
    output logic        dac_valid,
    output logic        busy,
    output logic [15:0] frame_cnt
);

    localparam int CW = $clog2(SAMPLE_DIV);

    typedef enum logic [2:0] {
        IDLE      = 3'd0,
        RAMP_UP   = 3'd1,
        DWELL_HI  = 3'd2,
        RAMP_DOWN = 3'd3,
        DWELL_LO  = 3'd4
    } state_t;

    state_t        state;
    state_t        state_n;
    logic [CW-1:0] tick_cnt;
    logic          tick;
    logic          start;
    logic          active_tick;

    // Scan parameters captured at start so mid-scan input changes are ignored
    logic [15:0]   lo_q;
    logic [15:0]   hi_q;
    logic [15:0]   step_q;
    logic [7:0]    dwell_q;

    logic [15:0]   pos;
    logic [7:0]    dcnt;
    logic          primed;

    logic [16:0]   sum;
    logic [16:0]   diff;
    logic [15:0]   up_val;
    logic [15:0]   dn_val;
    logic          up_hit;
    logic          dn_hit;
    logic          degen;

    logic [15:0]   emit;
    logic [15:0]   pos_n;
    logic [7:0]    dcnt_n;
    logic          primed_n;

    assign tick        = (tick_cnt == CW'(SAMPLE_DIV - 1));
    assign start       = (state == IDLE) && run;
    assign active_tick = (state != IDLE) && tick;

    // Saturating ramp arithmetic: 17-bit so neither direction can wrap
    assign sum    = {1'b0, pos} + {1'b0, step_q};
    assign diff   = {1'b0, pos} - {1'b0, step_q};
    assign up_val = (sum >= {1'b0, hi_q}) ? hi_q : sum[15:0];
    assign dn_val = (diff[16] || (diff[15:0] <= lo_q)) ? lo_q : diff[15:0];
    assign up_hit = (up_val == hi_q);
    assign dn_hit = (dn_val == lo_q);
    assign degen  = (lo_q >= hi_q);

    // State register
    always_ff @(posedge clk_ref) begin
        if (!sys_rstn) begin
            state <= IDLE;
        end else begin
            state <= state_n;
        end
    end

    // Next-state logic; active states only move on a sample tick
    always_comb begin
        state_n = state;
        if (state == IDLE) begin
            if (run) state_n = RAMP_UP;
        end else if (tick) begin
            if (!run) begin
                state_n = IDLE;
            end else begin
                case (state)
                    RAMP_UP: begin
                        if (!degen && primed && up_hit)
                            state_n = (dwell_q == 8'd0) ? RAMP_DOWN : DWELL_HI;
                    end
                    DWELL_HI: begin
                        if (dcnt == 8'd1) state_n = RAMP_DOWN;
                    end
                    RAMP_DOWN: begin
                        if (dn_hit)
                            state_n = (dwell_q == 8'd0) ? RAMP_UP : DWELL_LO;
                    end
                    DWELL_LO: begin
                        if (dcnt == 8'd1) state_n = RAMP_UP;
                    end
                    default: state_n = IDLE;
                endcase
            end
        end
    end

    // Output/datapath values for the coming tick; the first tick after start emits lim_lo unstepped
    always_comb begin
        emit     = pos;
        pos_n    = pos;
        dcnt_n   = dcnt;
        primed_n = primed;
        if (!run) begin
            emit = PARK_CODE;
        end else begin
            case (state)
                RAMP_UP: begin
                    if (degen || !primed) begin
                        emit     = lo_q;
                        pos_n    = lo_q;
                        primed_n = 1'b1;
                    end else begin
                        emit  = up_val;
                        pos_n = up_val;
                        if (up_hit) dcnt_n = dwell_q;
                    end
                end
                DWELL_HI: begin
                    emit   = hi_q;
                    dcnt_n = dcnt - 8'd1;
                end
                RAMP_DOWN: begin
                    emit  = dn_val;
                    pos_n = dn_val;
                    if (dn_hit) dcnt_n = dwell_q;
                end
                DWELL_LO: begin
                    emit   = lo_q;
                    dcnt_n = dcnt - 8'd1;
                end
                default: emit = PARK_CODE;
            endcase
        end
    end

    assign busy = (state != IDLE);

    // Sample divider: free-running, realigned so the first strobe lands SAMPLE_DIV cycles after start
    always_ff @(posedge clk_ref) begin
        if (!sys_rstn) begin
            tick_cnt <= '0;
        end else if (start || tick) begin
            tick_cnt <= '0;
        end else begin
            tick_cnt <= tick_cnt + CW'(1);
        end
    end

    // Parameter latch, ramp position and registered DAC strobe
    always_ff @(posedge clk_ref) begin
        if (!sys_rstn) begin
            lo_q      <= 16'd0;
            hi_q      <= 16'd0;
            step_q    <= 16'd1;
            dwell_q   <= 8'd0;
            pos       <= 16'd0;
            dcnt      <= 8'd0;
            primed    <= 1'b0;
            dac_data  <= PARK_CODE;
            dac_valid <= 1'b0;
        end else begin
            dac_valid <= 1'b0;
            if (start) begin
                lo_q    <= lim_lo;
                hi_q    <= lim_hi;
                step_q  <= (step == 16'd0) ? 16'd1 : step;
                dwell_q <= dwell;
                pos     <= lim_lo;
                dcnt    <= 8'd0;
                primed  <= 1'b0;
            end else if (active_tick) begin
                dac_valid <= 1'b1;
                dac_data  <= emit;
                pos       <= pos_n;
                dcnt      <= dcnt_n;
                primed    <= primed_n;
            end
        end
    end

`ifdef GALVO_FRAME_CNT_EN
    logic        frame_inc;
    logic [15:0] frame_q;

    // A frame completes when the low end is left for the next up-ramp
    assign frame_inc = active_tick && run &&
                       (((state == DWELL_LO) && (dcnt == 8'd1)) ||
                        ((state == RAMP_DOWN) && dn_hit && (dwell_q == 8'd0)));

    // Completed-scan counter, wraps naturally at 16 bits
    always_ff @(posedge clk_ref) begin
        if (!sys_rstn) begin
            frame_q <= 16'd0;
        end else if (frame_inc) begin
            frame_q <= frame_q + 16'd1;
        end
    end

    assign frame_cnt = frame_q;
`else
    assign frame_cnt = 16'd0;
`endif

endmodule
